// File: rtl/gain_cfg_serializer_if.sv
// rtl/gain_cfg_serializer_if.sv - gain word request and serial programming pins
interface gain_cfg_serializer_if #(
    parameter int GAIN1_W = 2,
    parameter int GAIN2_W = 3
);
    logic               i_start;
    logic [GAIN1_W-1:0] i_gain1;
    logic [GAIN2_W-1:0] i_gain2;
    logic               o_sclk;
    logic               o_sdin;
    logic               o_busy;
    logic               o_done;
    logic [GAIN1_W-1:0] o_last_gain1;
    logic [GAIN2_W-1:0] o_last_gain2;

    modport slave (
        input  i_start, i_gain1, i_gain2,
        output o_sclk, o_sdin, o_busy, o_done, o_last_gain1, o_last_gain2
    );

    modport master (
        output i_start, i_gain1, i_gain2,
        input  o_sclk, o_sdin, o_busy, o_done, o_last_gain1, o_last_gain2
    );
endinterface

// File: rtl/gain_cfg_serializer.sv
// rtl/gain_cfg_serializer.sv - shifts A1/A2 gain words LSB first on a divided sclk/sdin pair
module gain_cfg_serializer #(
    parameter int CLK_DIV = 4,
    parameter int GAIN1_W = 2,
    parameter int GAIN2_W = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    gain_cfg_serializer_if.slave  bus
);
    localparam int NB = GAIN1_W + GAIN2_W;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(NB + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

    state_t             r_state, w_state_n;
    logic [DW-1:0]      r_div_cnt, w_div_cnt_n;
    logic [BW-1:0]      r_bit_cnt, w_bit_cnt_n;
    logic [NB-1:0]      r_shift, w_shift_n;
    logic [NB-1:0]      r_frame, w_frame_n;
    logic               r_sclk, w_sclk_n;
    logic               r_sdin, w_sdin_n;
    logic               r_busy, w_busy_n;
    logic               r_done, w_done_n;
    logic [GAIN1_W-1:0] r_last_gain1, w_last_gain1_n;
    logic [GAIN2_W-1:0] r_last_gain2, w_last_gain2_n;
    logic [NB-1:0]      w_word;

    assign w_word = {bus.i_gain2, bus.i_gain1};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_frame      <= '0;
            r_sclk       <= 1'b0;
            r_sdin       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_last_gain1 <= '0;
            r_last_gain2 <= '0;
        end else begin
            r_state      <= w_state_n;
            r_div_cnt    <= w_div_cnt_n;
            r_bit_cnt    <= w_bit_cnt_n;
            r_shift      <= w_shift_n;
            r_frame      <= w_frame_n;
            r_sclk       <= w_sclk_n;
            r_sdin       <= w_sdin_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;
            r_last_gain1 <= w_last_gain1_n;
            r_last_gain2 <= w_last_gain2_n;
        end
    end

    // Outputs are computed one edge ahead so every pin comes straight from a flop.
    always_comb begin
        w_state_n      = r_state;
        w_div_cnt_n    = r_div_cnt;
        w_bit_cnt_n    = r_bit_cnt;
        w_shift_n      = r_shift;
        w_frame_n      = r_frame;
        w_sclk_n       = r_sclk;
        w_sdin_n       = r_sdin;
        w_busy_n       = r_busy;
        w_done_n       = 1'b0;
        w_last_gain1_n = r_last_gain1;
        w_last_gain2_n = r_last_gain2;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_frame_n   = w_word;
                    w_shift_n   = w_word >> 1;
                    w_sdin_n    = w_word[0];
                    w_sclk_n    = 1'b0;
                    w_busy_n    = 1'b1;
                    w_div_cnt_n = '0;
                    w_bit_cnt_n = '0;
                    w_state_n   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_n = '0;
                    w_sclk_n    = 1'b1;
                    w_state_n   = ST_HIGH;
                end else begin
                    w_div_cnt_n = r_div_cnt + DW'(1);
                end
            end
            ST_HIGH: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt_n = '0;
                    w_sclk_n    = 1'b0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_cnt_n    = '0;
                        w_sdin_n       = 1'b0;
                        w_busy_n       = 1'b0;
                        w_done_n       = 1'b1;
                        w_last_gain1_n = r_frame[GAIN1_W-1:0];
                        w_last_gain2_n = r_frame[NB-1:GAIN1_W];
                        w_state_n      = ST_DONE;
                    end else begin
                        // Next bit goes out on the same edge sclk falls, giving full CLK_DIV setup.
                        w_sdin_n    = r_shift[0];
                        w_shift_n   = r_shift >> 1;
                        w_bit_cnt_n = r_bit_cnt + BW'(1);
                        w_state_n   = ST_LOW;
                    end
                end else begin
                    w_div_cnt_n = r_div_cnt + DW'(1);
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.o_sclk       = r_sclk;
    assign bus.o_sdin       = r_sdin;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_last_gain1 = r_last_gain1;
    assign bus.o_last_gain2 = r_last_gain2;
endmodule
